mem_arbiter: RTL

Arbitrates one physical-memory port between the CPU's two cache-line requesters: port A (instruction-side, read-only) and port B (data-side, read/write). It sits between the I-cache/D-cache miss paths and the shared physical memory. It grants one whole line transaction at a time using round-robin priority. Grant counters are exposed for performance debug.

---
 rtl/rv32i_types.sv | 14 +
 rtl/arb_grant_counter.sv | 19 +
 rtl/mem_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types; holds the memory-arbiter state encoding and default line width.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_A,
    BUSY_B
  } arb_state_t;

  localparam int LINE_W_DEFAULT = 256;

endpackage

// File: rtl/arb_grant_counter.sv
// Wrapping 32-bit event counter with asynchronous active-low clear.
module arb_grant_counter
  import rv32i_types::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      inc,
  output rv32i_word count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting whole cache-line transactions on one memory port
// to the I-side (A, read-only) and D-side (B, read/write) miss paths.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W = LINE_W_DEFAULT,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_read,
  input  logic [ADDR_W-1:0] a_address,
  output logic [LINE_W-1:0] a_rdata,
  output logic              a_resp,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [LINE_W-1:0] b_wdata,
  output logic [LINE_W-1:0] b_rdata,
  output logic              b_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [31:0]       grant_cnt_a,
  output logic [31:0]       grant_cnt_b
);

  arb_state_t state, state_next;
  logic       last_b;
  logic       write_op;
  logic       b_req;
  logic       grant_a;
  logic       grant_b;

  assign b_req = b_read | b_write;

  always_comb begin
    state_next = state;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the port that did not win last time goes next.
        if (a_read && b_req) begin
          grant_a = last_b;
          grant_b = !last_b;
        end else begin
          grant_a = a_read;
          grant_b = b_req;
        end
        if (grant_a) state_next = BUSY_A;
        if (grant_b) state_next = BUSY_B;
      end
      BUSY_A, BUSY_B: begin
        if (pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_b       <= 1'b0;
      write_op     <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      state <= state_next;
      if (grant_a) begin
        last_b       <= 1'b0;
        write_op     <= 1'b0;
        pmem_address <= a_address;
      end
      // A simultaneous b_read is ignored when b_write is set: write wins.
      if (grant_b) begin
        last_b       <= 1'b1;
        write_op     <= b_write;
        pmem_address <= b_address;
        pmem_wdata   <= b_wdata;
      end
    end
  end

  assign pmem_read  = (state != IDLE) && !write_op;
  assign pmem_write = (state != IDLE) && write_op;

  assign a_resp  = (state == BUSY_A) && pmem_resp;
  assign b_resp  = (state == BUSY_B) && pmem_resp;
  assign a_rdata = a_resp ? pmem_rdata : '0;
  assign b_rdata = b_resp ? pmem_rdata : '0;

  arb_grant_counter u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (a_resp),
    .count (grant_cnt_a)
  );

  arb_grant_counter u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (b_resp),
    .count (grant_cnt_b)
  );

endmodule
